// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter with a one-word holding register.
// Words are accepted on a valid/ready handshake, serialized one bit per enabled
// cycle, and back-to-back words are chained without a gap in q_valid.
module piso_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             ie,
  input  logic             en,
  input  logic             oe,
  output logic             q,
  output logic             q_valid,
  output logic             done,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_shreg;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_hold;
  logic               r_hold_valid;

  logic               w_accept;
  logic               w_last;
  logic               w_bit;
  logic [WIDTH-1:0]   w_shifted;

  // Handshake and serial outputs are combinational views of the registered state;
  // every output is forced low while reset is asserted.
  assign din_ready = rst & ie & ~r_hold_valid;
  assign w_accept  = din_valid & din_ready;
  assign q_valid   = rst & (r_state == SHIFT) & en;
  assign w_last    = q_valid & (r_cnt == LAST_CNT);
  assign done      = w_last;
  assign busy      = rst & ((r_state == SHIFT) | r_hold_valid);
  assign w_bit     = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
  assign q         = rst & oe & w_bit;
  // Shift toward the output end, zero-filling so the register drains to 0.
  assign w_shifted = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0}
                               : {1'b0, r_shreg[WIDTH-1:1]};

  // Two-state FSM owning the shift register, bit counter and holding register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_shreg      <= '0;
      r_cnt        <= '0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // en is irrelevant here: a word starts shifting on the very next cycle.
          if (w_accept) begin
            r_shreg <= din;
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_last) begin
            // Last bit leaves this edge: chain the next word with no gap.
            if (r_hold_valid) begin
              r_shreg      <= r_hold;
              r_cnt        <= '0;
              r_hold_valid <= w_accept;
              if (w_accept) r_hold <= din;
            end else if (w_accept) begin
              r_shreg <= din;
              r_cnt   <= '0;
            end else begin
              r_shreg <= w_shifted;
              r_cnt   <= '0;
              r_state <= IDLE;
            end
          end else begin
            // Stalls (en=0) freeze shifting but a word may still be parked in hold.
            if (en) begin
              r_shreg <= w_shifted;
              r_cnt   <= r_cnt + CNT_W'(1);
            end
            if (w_accept) begin
              r_hold       <= din;
              r_hold_valid <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed, table-driven bench for piso_tx (WIDTH=8, MSB first).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_piso_tx;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       ie;
  logic       en;
  logic       oe;
  logic       q;
  logic       q_valid;
  logic       done;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  logic [15:0] sipo;

  piso_tx #(.WIDTH(8), .MSB_FIRST(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .ie        (ie),
    .en        (en),
    .oe        (oe),
    .q         (q),
    .q_valid   (q_valid),
    .done      (done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two chained 8-bit SIPOs fed from the serial link (q -> d, q_valid -> ie).
  always @(posedge clk) begin
    if (q_valid) sipo <= {sipo[14:0], q};
  end

  typedef struct {
    logic       rst, ie, en, oe, dv;
    logic [7:0] din;
    logic       q, qv, dn, bsy, rdy;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(logic r, logic i, logic e, logic o, logic v, logic [7:0] d,
                              logic eq, logic eqv, logic edn, logic eb, logic er);
    vec_t t;
    t.rst = r; t.ie = i; t.en = e; t.oe = o; t.dv = v; t.din = d;
    t.q = eq; t.qv = eqv; t.dn = edn; t.bsy = eb; t.rdy = er;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic i, input logic e, input logic o,
                       input logic v, input logic [7:0] d);
    rst = r; ie = i; en = e; oe = o; din_valid = v; din = d;
  endtask

  task automatic expect5(input string tag, input logic eq, input logic eqv, input logic edn,
                         input logic eb, input logic er);
    chk({tag, ".q"},         {15'd0, q},         {15'd0, eq});
    chk({tag, ".q_valid"},   {15'd0, q_valid},   {15'd0, eqv});
    chk({tag, ".done"},      {15'd0, done},      {15'd0, edn});
    chk({tag, ".busy"},      {15'd0, busy},      {15'd0, eb});
    chk({tag, ".din_ready"}, {15'd0, din_ready}, {15'd0, er});
  endtask

  // One cycle: apply inputs, sample outputs, advance past the rising edge.
  task automatic cyc(input string tag, input logic r, input logic i, input logic e,
                     input logic o, input logic v, input logic [7:0] d,
                     input logic eq, input logic eqv, input logic edn,
                     input logic eb, input logic er);
    drive(r, i, e, o, v, d);
    #1;
    expect5(tag, eq, eqv, edn, eb, er);
    @(negedge clk);
  endtask

  // Eight bit cycles of a word accepted on the previous edge, then one idle cycle.
  task automatic run_word(input string tag, input logic [7:0] w, input logic o);
    for (int i = 0; i < 8; i++)
      cyc($sformatf("%s.bit%0d", tag, i), 1, 1, 1, o, 0, 8'h00,
          o & w[7-i], 1'b1, (i == 7), 1'b1, 1'b1);
    cyc({tag, ".idle"}, 1, 1, 1, 1, 0, 8'h00, 0, 0, 0, 0, 1);
  endtask

  // Word w1 accepted from IDLE, w2 offered next cycle and held with din_valid high.
  task automatic b2b(input string tag, input logic [7:0] w1, input logic [7:0] w2);
    logic [15:0] pair;
    pair = {w1, w2};
    cyc({tag, ".acc1"}, 1, 1, 1, 1, 1, w1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++)
      cyc($sformatf("%s.bit%0d", tag, i), 1, 1, 1, 1, (i < 8), w2,
          pair[15-i], 1'b1, (i == 7 || i == 15), 1'b1, (i == 0 || i >= 8));
    cyc({tag, ".idle"}, 1, 1, 1, 1, 0, 8'h00, 0, 0, 0, 0, 1);
  endtask

  initial begin
    logic [7:0] wa5;
    logic [7:0] w81;
    logic [7:0] wf0;
    logic [2:0] en_pat_idx;
    int         bidx;
    int         nvalid;
    logic       en_pat[11];

    wa5 = 8'hA5;
    tbl[0]  = mk(0, 1, 1, 1, 0, 8'h00, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 1, 1, 1, 8'hFF, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 1, 1, 1, 0, 8'h00, 0, 0, 0, 0, 1);
    tbl[3]  = mk(1, 1, 1, 1, 1, 8'hA5, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++)
      tbl[4+i] = mk(1, 1, 1, 1, 0, 8'h00, wa5[7-i], 1, (i == 7), 1, 1);
    tbl[12] = mk(1, 1, 1, 1, 0, 8'h00, 0, 0, 0, 0, 1);
    tbl[13] = mk(1, 0, 1, 1, 1, 8'hFF, 0, 0, 0, 0, 0);
    tbl[14] = mk(1, 1, 1, 1, 0, 8'h00, 0, 0, 0, 0, 1);

    // Hold reset across one rising edge before the first sampled row.
    drive(0, 1, 1, 1, 0, 8'h00);
    @(negedge clk);

    // Reset state, single word 0xA5, idle return, and ie=0 blocking acceptance.
    for (int r = 0; r < 15; r++)
      cyc($sformatf("row%0d", r), tbl[r].rst, tbl[r].ie, tbl[r].en, tbl[r].oe,
          tbl[r].dv, tbl[r].din, tbl[r].q, tbl[r].qv, tbl[r].dn, tbl[r].bsy, tbl[r].rdy);

    // Back-to-back 0xA5 / 0x3C: 16 contiguous bits, hold full blocks din_ready.
    b2b("b2b", 8'hA5, 8'h3C);

    // Stall: en low for 3 cycles after the third bit of 0x81.
    w81 = 8'h81;
    en_pat = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
    cyc("stall.acc", 1, 1, 1, 1, 1, w81, 0, 0, 0, 0, 1);
    bidx = 0;
    nvalid = 0;
    for (int c = 0; c < 11; c++) begin
      drive(1, 1, en_pat[c], 1, 0, 8'h00);
      #1;
      expect5($sformatf("stall.c%0d", c), w81[7-bidx], en_pat[c],
              en_pat[c] & (bidx == 7), 1'b1, 1'b1);
      if (q_valid) nvalid++;
      if (en_pat[c]) bidx++;
      @(negedge clk);
    end
    chk("stall.valid_count", 16'(nvalid), 16'd8);
    cyc("stall.idle", 1, 1, 1, 1, 0, 8'h00, 0, 0, 0, 0, 1);

    // oe=0 over 0xFF: q stays low, framing unchanged.
    cyc("oe0.acc", 1, 1, 1, 0, 1, 8'hFF, 0, 0, 0, 0, 1);
    run_word("oe0", 8'hFF, 1'b0);

    // Reset after the 4th bit of 0xF0 with 0x0F held, then a fresh 0x55.
    wf0 = 8'hF0;
    cyc("rstmid.acc1", 1, 1, 1, 1, 1, wf0, 0, 0, 0, 0, 1);
    cyc("rstmid.bit0", 1, 1, 1, 1, 1, 8'h0F, wf0[7], 1, 0, 1, 1);
    for (int i = 1; i < 4; i++)
      cyc($sformatf("rstmid.bit%0d", i), 1, 1, 1, 1, 0, 8'h00, wf0[7-i], 1, 0, 1, 0);
    cyc("rstmid.rst0", 0, 1, 1, 1, 0, 8'h00, 0, 0, 0, 0, 0);
    cyc("rstmid.rst1", 0, 1, 1, 1, 1, 8'h55, 0, 0, 0, 0, 0);
    cyc("rstmid.acc2", 1, 1, 1, 1, 1, 8'h55, 0, 0, 0, 0, 1);
    run_word("rstmid.w55", 8'h55, 1'b1);

    // Loopback into two chained SIPOs.
    b2b("loop", 8'h12, 8'h34);
    chk("loop.sipo", sipo, 16'h1234);

    en_pat_idx = '0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8: parallel word width, minimum 2.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 is sent first, 0 = bit 0 is sent first.
REQ-003 SHALL have port clk, input, 1: single clock, rising-edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port din, input, WIDTH: parallel word to serialize.
REQ-006 SHALL have port din_valid, input, 1: din holds a word to transfer.
REQ-007 SHALL have port din_ready, output, 1: block can accept a word this cycle.
REQ-008 SHALL have port ie, input, 1: input enable; 0 blocks all word acceptance.
REQ-009 SHALL have port en, input, 1: shift enable; 0 freezes all shift state.
REQ-010 SHALL have port oe, input, 1: output enable for q.
REQ-011 SHALL have port q, output, 1: serial data bit, intended for the downstream SIPO d input.
REQ-012 SHALL have port q_valid, output, 1: q carries a frame bit this cycle, intended for the downstream SIPO ie input.
REQ-013 SHALL have port done, output, 1: one-cycle pulse while the last bit of a word is on q.
REQ-014 SHALL have port busy, output, 1: state is SHIFT or the holding register is occupied.

Function
REQ-015 SHALL contain a WIDTH-bit shift register, a bit counter of width clog2(WIDTH), a one-word holding register with a hold_valid flag, and a two-state FSM (IDLE, SHIFT).
REQ-016 SHALL drive din_ready = rst & ie & ~hold_valid, combinationally.
REQ-017 SHALL treat a word as accepted at a rising edge where din_valid & din_ready = 1.
REQ-018 SHALL, in IDLE on accept, load din into the shift register, clear the counter, and go to SHIFT; en has no effect in IDLE.
REQ-019 SHALL, in SHIFT on accept, store din in the holding register and set hold_valid, unless that same edge is a last-bit edge with hold empty; in that case din loads directly into the shift register.
REQ-020 SHALL drive q_valid = (state==SHIFT) & en.
REQ-021 SHALL drive q = oe & current bit, where the current bit is shift register bit WIDTH-1 if MSB_FIRST, otherwise bit 0. oe SHALL NOT affect the shift register, counter or FSM.
REQ-022 SHALL, on each SHIFT edge with en=1, shift toward the output end and increment the counter.
REQ-023 SHALL drive done = q_valid & (counter==WIDTH-1).
REQ-024 SHALL, on a last-bit edge, do exactly one of the following: if hold_valid=1, load the holding register into the shift register, clear the counter and hold_valid, and stay in SHIFT; else if accept, load din and stay in SHIFT; else go to IDLE.
REQ-025 SHALL, on an edge where hold_valid is cleared, allow a simultaneous accept to refill the holding register. din_ready SHALL still read 0 in that cycle, so this case does not arise from a compliant source.
REQ-026 SHALL give first-bit latency of exactly one cycle: a word accepted at edge k appears on q with q_valid=1 in the cycle after edge k, given en=1.
REQ-027 SHALL produce a continuous frame (no q_valid gap) for back-to-back words whenever the next word is accepted no later than the last-bit edge of the current word.
REQ-028 SHALL, when en=0, hold state, counter, shift register and hold contents; bit order SHALL be unaffected by stalls of any length.
REQ-029 SHALL NOT drop, duplicate or reorder accepted words.

Reset
REQ-030 SHALL, when rst=0 at a rising edge, set state=IDLE, shift register=0, counter=0, holding register=0 and hold_valid=0, overriding any accept or shift on that edge.
REQ-031 SHALL, during and after reset, produce q=0, q_valid=0, done=0, busy=0 and din_ready=0 while rst=0; din_ready=ie after release.
REQ-032 SHALL, on reset mid-frame, discard the partially sent word and any held word; the next accepted word starts a fresh frame.

Verification (WIDTH=8, MSB_FIRST=1, ie=en=oe=1 unless stated)
REQ-033 Single word: accept 0xA5 at edge k -> q = 1,0,1,0,0,1,0,1 on cycles k+1..k+8, q_valid high for those 8 cycles only, done on cycle k+8, then IDLE.
REQ-034 Back-to-back: 0xA5, then 0x3C held while din_valid stays high -> 16 contiguous q_valid cycles, bits 10100101 00111100, done on the 8th and 16th cycles, din_ready low while hold is full.
REQ-035 Stall: en=0 for 3 cycles after the 3rd bit of 0x81 -> q_valid low and q frozen for those cycles; remaining bits resume in order; 8 valid bits total.
REQ-036 oe=0 throughout 0xFF -> q=0 for all cycles; q_valid and done timing identical to oe=1.
REQ-037 Reset after the 4th bit of 0xF0 with 0x0F held -> next cycle q_valid=0, busy=0, din_ready=0 during reset; a new word 0x55 after release serializes fully and correctly.
REQ-038 Loopback into two chained 8-bit SIPOs (q->d, q_valid->ie): send 0x12 then 0x34 -> SIPO pair reads 0x1234 after the second done.
